// File: rtl/data_sync_pkg.sv
// data_sync_pkg: state encoding and shared defaults for the Data_Sync transmitter/receiver pair.
`default_nettype none

package data_sync_pkg;

   localparam int DEFAULT_NUM_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      REQ     = 2'b01,
      RELEASE = 2'b10
   } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// bit_sync: NUM_STAGES-flop single-bit synchronizer, asynchronous active-low reset.
`default_nettype none

module bit_sync
   import data_sync_pkg::*;
#(
   parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
   input  logic CLK,
   input  logic RST,
   input  logic d_i,
   output logic q_o
);

   logic [NUM_STAGES-1:0] sync_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[NUM_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side 4-phase request/ack transmitter feeding a Data_Sync receiver.
// Define DATA_SYNC_TX_PARITY_EN to append even parity as the MSB of Unsync_bus.
`default_nettype none

module data_sync_tx
   import data_sync_pkg::*;
#(
   parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 ack_async,
`ifdef DATA_SYNC_TX_PARITY_EN
   output logic [BUS_WIDTH:0]   Unsync_bus,
`else
   output logic [BUS_WIDTH-1:0] Unsync_bus,
`endif
   output logic                 bus_enable,
   output logic                 busy,
   output logic                 done_pulse
);

`ifdef DATA_SYNC_TX_PARITY_EN
   localparam int OUT_W = BUS_WIDTH + 1;
`else
   localparam int OUT_W = BUS_WIDTH;
`endif

   tx_state_e              state_q, state_d;
   logic [OUT_W-1:0]       hold_q, hold_d;
   logic                   en_q, en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [NUM_STAGES-1:0]  arm_q;
   logic                   ack_sync;
   logic                   ready_w;

   bit_sync #(
      .NUM_STAGES (NUM_STAGES)
   ) u_ack_sync (
      .CLK (CLK),
      .RST (RST),
      .d_i (ack_async),
      .q_o (ack_sync)
   );

   // ack_sync is only trustworthy once the chain has refilled after reset,
   // otherwise a stale high ack would be masked for NUM_STAGES cycles.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         arm_q <= '0;
      end else begin
         arm_q <= {arm_q[NUM_STAGES-2:0], 1'b1};
      end
   end

   assign ready_w  = (state_q == IDLE) && !ack_sync && arm_q[NUM_STAGES-1];
   assign tx_ready = ready_w;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_valid && ready_w) begin
               state_d = REQ;
`ifdef DATA_SYNC_TX_PARITY_EN
               hold_d  = {^tx_data, tx_data};
`else
               hold_d  = tx_data;
`endif
            end
         end
         REQ: begin
            if (ack_sync) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!ack_sync) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      en_d   = (state_d == REQ);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         hold_q  <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Unsync_bus = hold_q;
   assign bus_enable = en_q;
   assign busy       = busy_q;
   assign done_pulse = done_q;

endmodule

`default_nettype wire

// File: doc/data_sync_tx.md
Name: data_sync_tx

Overview:
- Source-domain transmitter for the multi-flop bus synchronizer receiver (Data_Sync).
- Accepts a word via valid/ready, then holds it stable on Unsync_bus.
- Drives bus_enable as a 4-phase request level and waits for the destination acknowledge, synchronized back into CLK.
- One instance per clock-domain crossing (e.g. register file to UART TX domain), paired with one Data_Sync instance in the destination domain.

Parameters:
- NUM_STAGES, 2, flops in the ack synchronizer chain (≥2).
- BUS_WIDTH, 8, data width.

Ports:
- CLK  in  1  source-domain clock.
- RST  in  1  reset, asynchronous, active-low.
- tx_data  in  BUS_WIDTH  word to transfer.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  block can accept a word this cycle.
- ack_async  in  1  destination acknowledge level (destination-domain synchronized enable), asynchronous to CLK.
- Unsync_bus  out  BUS_WIDTH (+1 with parity feature)  held data to the receiver.
- bus_enable  out  1  request level to the receiver.
- busy  out  1  handshake in progress.
- done_pulse  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, ack synchronizer cleared. This includes Unsync_bus, bus_enable, busy, done_pulse and tx_ready.
- ack_sync is the last stage of the NUM_STAGES-flop chain on ack_async. Only ack_sync is used in logic.
- FSM states and transitions:
  - IDLE:
    - tx_ready = (ack_sync == 0).
    - On tx_valid & tx_ready at edge N: capture tx_data into the hold register, go to REQ.
    - Unsync_bus and bus_enable both update at edge N (registered). Bus stability at the receiver is guaranteed by its NUM_STAGES enable delay.
  - REQ:
    - bus_enable=1, busy=1, tx_ready=0.
    - On ack_sync==1 go to RELEASE.
  - RELEASE:
    - bus_enable=0, busy=1, tx_ready=0.
    - On ack_sync==0: go to IDLE and assert done_pulse for exactly one cycle (registered, same edge as the IDLE entry).
- Hold register: written only on acceptance in IDLE. Unsync_bus is constant from acceptance until the next acceptance, including all of REQ and RELEASE.
- tx_valid while not ready: ignored, no capture. The source must hold the word until it is accepted.
- Back-to-back transfers: tx_ready may be 1 in the cycle IDLE is entered. Minimum gap between bus_enable rising edges is 2 + round-trip synchronizer latency.
- ack_async high out of reset (stale destination): stay in IDLE with tx_ready=0 until ack_sync==0.
- ack_async glitch while in IDLE: no effect beyond blocking tx_ready.
- Reset mid-handshake: immediate return to IDLE, bus_enable=0, Unsync_bus=0, no done_pulse. The receiver sees a falling enable with no new rising edge, so no spurious capture occurs.
- No combinational path from ack_async to any output.

Optional Feature:
- Macro: DATA_SYNC_TX_PARITY_EN.
- Defined:
  - Unsync_bus is BUS_WIDTH+1 bits; the MSB is the even parity (XOR) of the held data, computed at capture and registered with the data.
  - The receiver's BUS_WIDTH parameter is set to BUS_WIDTH+1.
- Undefined: Unsync_bus is exactly BUS_WIDTH, with no parity logic.

Decomposition:
- Shared package data_sync_pkg:
  - FSM state encoding: IDLE=2'b00, REQ=2'b01, RELEASE=2'b10.
  - Default NUM_STAGES constant shared with the Data_Sync receiver.
- Sub-module bit_sync: a NUM_STAGES-flop single-bit synchronizer with async active-low reset. It is used for the ack path and is reusable elsewhere.

Test Plan:
- Single transfer:
  - Stimulus: tx_data=8'hA5, tx_valid 1 cycle; ack_async driven high 3 cycles after bus_enable rises, low 3 cycles after bus_enable falls.
  - Required response: Unsync_bus=8'hA5 and bus_enable=1 one cycle after accept; bus_enable=0 NUM_STAGES cycles after ack_async rises; done_pulse for exactly 1 cycle; tx_ready back to 1.
- Busy rejection:
  - Stimulus: second word 8'h3C presented during REQ.
  - Required response: tx_ready=0, Unsync_bus stays 8'hA5; 8'h3C captured only after done_pulse.
- Stale ack at reset:
  - Stimulus: release RST with ack_async=1, tx_valid=1.
  - Required response: tx_ready=0, bus_enable=0 until ack_async goes low plus NUM_STAGES cycles.
- Reset mid-REQ:
  - Stimulus: RST low during REQ.
  - Required response: bus_enable, Unsync_bus and busy go to 0 asynchronously; no done_pulse.
- Paired loopback:
  - Stimulus: connect to Data_Sync in an unrelated clock (CLK 10 ns, destination 37 ns); send 8'h01..8'h10 back-to-back with ack = the receiver's synchronized enable.
  - Required response: 16 enable_pulses, Sync_bus sequence exactly 8'h01..8'h10.
- Parity (macro defined):
  - Stimulus: send 8'h07.
  - Required response: Unsync_bus=9'h107.
